// File: rtl/dualmem_line_reader_pkg.sv
// Shared widths, derived beat count and FSM state type for the dual-port line memory clients.
package dualmem_pkg;

  function automatic int unsigned calc_nbeats(input int unsigned line_w, input int unsigned beat_w);
    return (line_w + beat_w - 1) / beat_w;
  endfunction

  localparam int unsigned LINE_W = 1260;
  localparam int unsigned BEAT_W = 36;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned NBEATS = calc_nbeats(LINE_W, BEAT_W);
  localparam int unsigned IDX_W  = $clog2(NBEATS);
  // Line zero-extended to a whole number of beats so the last part-select stays in range.
  localparam int unsigned PAD_W  = NBEATS * BEAT_W;
  localparam int unsigned OFS_W  = $clog2(PAD_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } rd_state_e;

endpackage

// File: rtl/dualmem_line_reader_if.sv
// Request, memory read port and beat stream of the line reader; slave is the reader side.
interface dualmem_line_reader_if;
  import dualmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_rdata;
  logic              beat_valid;
  logic              beat_ready;
  logic [BEAT_W-1:0] beat_data;
  logic              beat_last;
  logic [IDX_W-1:0]  beat_idx;

  modport slave (
    input  req_valid, req_addr, mem_rdata, beat_ready,
    output req_ready, mem_en, mem_addr, beat_valid, beat_data, beat_last, beat_idx
  );

  modport master (
    output req_valid, req_addr, mem_rdata, beat_ready,
    input  req_ready, mem_en, mem_addr, beat_valid, beat_data, beat_last, beat_idx
  );

endinterface

// File: rtl/dualmem_line_reader.sv
// Reads one line from a memory port, snapshots it, and streams it LSB-first as BEAT_W beats.
module dualmem_line_reader
  import dualmem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  dualmem_line_reader_if.slave  bus
);

  rd_state_e         r_state;
  rd_state_e         w_state_nxt;
  logic [IDX_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  w_cnt_nxt;
  logic [LINE_W-1:0] r_line;
  logic [PAD_W-1:0]  w_line_pad;
  logic [OFS_W-1:0]  w_ofs;
  logic              w_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Snapshot: memory data is valid in the cycle after mem_en, which is always WAIT.
  always_ff @(posedge clk) begin
    if (r_state == WAIT) begin
      r_line <= bus.mem_rdata;
    end
  end

  assign w_line_pad = PAD_W'(r_line);
  assign w_ofs      = OFS_W'(r_cnt) * OFS_W'(BEAT_W);
  assign w_last     = (r_cnt == IDX_W'(NBEATS - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    bus.req_ready  = 1'b0;
    bus.mem_en     = 1'b0;
    bus.mem_addr   = '0;
    bus.beat_valid = 1'b0;
    bus.beat_data  = '0;
    bus.beat_last  = 1'b0;
    bus.beat_idx   = '0;
    unique case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        bus.mem_en    = bus.req_valid;
        bus.mem_addr  = bus.req_addr;
        if (bus.req_valid) begin
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        w_cnt_nxt   = '0;
        w_state_nxt = STREAM;
      end
      STREAM: begin
        bus.beat_valid = 1'b1;
        bus.beat_data  = w_line_pad[w_ofs +: BEAT_W];
        bus.beat_last  = w_last;
        bus.beat_idx   = r_cnt;
        if (bus.beat_ready) begin
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

endmodule
